// File: rtl/cntr_bs_sch_rr.sv
// Bank scheduler: round-robin FIFO pick within the active read/write class,
// then streams same-burst hits up to MAX_HITS pops before re-arbitrating.
module cntr_bs_sch_rr #(
    parameter logic READ        = 1'b1,
    parameter logic WRITE       = 1'b0,
    parameter int   RD_FIFO_NUM = 4,
    parameter int   WR_FIFO_NUM = 3,
    parameter int   BURST       = 16,
    parameter int   MAX_HITS    = 8,
    localparam int  FIFO_NUM    = RD_FIFO_NUM + WR_FIFO_NUM,
    localparam int  SEL_W       = (FIFO_NUM > 1) ? $clog2(FIFO_NUM) : 1,
    localparam int  CNT_W       = $clog2(MAX_HITS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ready,
    input  logic                           mode,
    input  logic [FIFO_NUM-1:0][BURST-1:0] burst_i,
    input  logic [FIFO_NUM-1:0]            empty,
    output logic [FIFO_NUM-1:0]            pop,
    output logic                           valid_o,
    output logic [SEL_W-1:0]               sel_o,
    output logic [BURST-1:0]               burst_o
);

    typedef enum logic [1:0] {IDLE, ARB, STREAM} state_t;

    state_t            cs;
    logic [BURST-1:0]  cb;
    logic [SEL_W-1:0]  rd_ptr;
    logic [SEL_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  hit_cnt;

    logic                is_rd;
    logic [FIFO_NUM-1:0] cls;
    logic [FIFO_NUM-1:0] avail;
    logic [FIFO_NUM-1:0] hits;
    logic [FIFO_NUM-1:0] cand;
    logic                found;
    logic                go;
    logic [SEL_W-1:0]    sel;
    int                  base;
    int                  n;
    int                  ptr;
    int                  start;
    int                  best_d;
    int                  d;
    int                  lk;
    int                  loc;

    // Scan by modular distance from the start index so wrap follows class size.
    always_comb begin
        is_rd  = (mode == READ);
        base   = is_rd ? 0 : RD_FIFO_NUM;
        n      = is_rd ? RD_FIFO_NUM : WR_FIFO_NUM;
        ptr    = is_rd ? int'(rd_ptr) : int'(wr_ptr);
        cls    = '0;
        hits   = '0;
        for (int k = 0; k < FIFO_NUM; k++) begin
            cls[k] = (k < RD_FIFO_NUM) ? (mode == READ) : (mode == WRITE);
        end
        avail = ~empty & cls;
        for (int k = 0; k < FIFO_NUM; k++) begin
            hits[k] = avail[k] && (burst_i[k] == cb);
        end
        cand   = (cs == STREAM) ? hits : avail;
        start  = (cs == STREAM) ? ptr : ((ptr + 1 >= n) ? 0 : ptr + 1);
        found  = 1'b0;
        loc    = 0;
        lk     = 0;
        d      = 0;
        best_d = FIFO_NUM;
        for (int k = 0; k < FIFO_NUM; k++) begin
            if (cand[k]) begin
                lk = k - base;
                d  = lk - start;
                if (d < 0) d = d + n;
                if (d < best_d) begin
                    best_d = d;
                    loc    = lk;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        unique case (cs)
            ARB:     go = found;
            STREAM:  go = found && (hit_cnt < CNT_W'(MAX_HITS));
            default: go = 1'b0;
        endcase
    end

    assign sel     = SEL_W'(base + loc);
    assign valid_o = go & ~rst;
    assign sel_o   = valid_o ? sel : '0;
    assign burst_o = burst_i[sel_o];
    assign pop     = (valid_o && ready) ? (FIFO_NUM'(1) << sel_o) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs      <= IDLE;
            cb      <= '0;
            rd_ptr  <= SEL_W'(RD_FIFO_NUM - 1);
            wr_ptr  <= SEL_W'(WR_FIFO_NUM - 1);
            hit_cnt <= '0;
        end else begin
            unique case (cs)
                IDLE: begin
                    if (|avail) cs <= ARB;
                end
                ARB: begin
                    if (!found) begin
                        cs <= IDLE;
                    end else if (ready) begin
                        cb      <= burst_i[sel];
                        hit_cnt <= CNT_W'(1);
                        cs      <= STREAM;
                        if (is_rd) rd_ptr <= SEL_W'(loc);
                        else       wr_ptr <= SEL_W'(loc);
                    end
                end
                STREAM: begin
                    if (!go) begin
                        cs <= ARB;
                    end else if (ready) begin
                        if (hit_cnt != CNT_W'(MAX_HITS)) hit_cnt <= hit_cnt + CNT_W'(1);
                        if (is_rd) rd_ptr <= SEL_W'(loc);
                        else       wr_ptr <= SEL_W'(loc);
                    end
                end
                default: cs <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cntr_bs_sch_rr.sv
// Bench for cntr_bs_sch_rr: cycle tables per scenario, FIFO model as the
// environment, and a pop scoreboard checking index and burst of every pop.
module tb_cntr_bs_sch_rr;

    localparam int FN = 7;
    localparam int BW = 16;
    localparam logic R = 1'b1;
    localparam logic W = 1'b0;

    logic                   clk;
    logic                   rst;
    logic                   ready;
    logic                   mode;
    logic [FN-1:0][BW-1:0]  burst_i;
    logic [FN-1:0]          empty;
    logic [FN-1:0]          pop;
    logic                   valid_o;
    logic [2:0]             sel_o;
    logic [BW-1:0]          burst_o;

    cntr_bs_sch_rr #(
        .READ(1'b1), .WRITE(1'b0), .RD_FIFO_NUM(4), .WR_FIFO_NUM(3),
        .BURST(BW), .MAX_HITS(8)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready), .mode(mode),
        .burst_i(burst_i), .empty(empty), .pop(pop),
        .valid_o(valid_o), .sel_o(sel_o), .burst_o(burst_o)
    );

    typedef struct {
        logic          ready;
        logic          mode;
        int            exp;
        logic [BW-1:0] bst;
    } vec_t;

    typedef struct {
        int            idx;
        logic [BW-1:0] bst;
    } sbe_t;

    vec_t          vecs[$];
    sbe_t          sb[$];
    logic [BW-1:0] fq[FN][$];
    logic [FN-1:0] pend;
    int            nvec;
    int            nerr;

    always #5 clk = ~clk;

    function automatic void refresh();
        for (int k = 0; k < FN; k++) begin
            if (fq[k].size() != 0) begin
                empty[k]   = 1'b0;
                burst_i[k] = fq[k][0];
            end else begin
                empty[k]   = 1'b1;
                burst_i[k] = 16'hE000 | 16'(k);
            end
        end
    endfunction

    // FIFO model: consume heads popped at the edge, then present new heads.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < FN; k++) begin
            if (pend[k] && fq[k].size() != 0) void'(fq[k].pop_front());
        end
        pend = '0;
        #1;
        refresh();
    end

    always @(negedge clk) begin
        sbe_t e;
        pend = pop;
        if (|pop) begin
            nvec++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL sb_unexpected: pop=%b burst=%h, want no pop", pop, burst_o);
            end else begin
                e = sb.pop_front();
                if (pop != (FN'(1) << e.idx) || burst_o != e.bst) begin
                    nerr++;
                    $display("FAIL sb_pop: pop=%b burst=%h, want fifo %0d burst=%h",
                             pop, burst_o, e.idx, e.bst);
                end
            end
        end
    end

    task automatic add(input logic r, input logic m, input int e, input logic [BW-1:0] b);
        vec_t v;
        v.ready = r;
        v.mode  = m;
        v.exp   = e;
        v.bst   = b;
        vecs.push_back(v);
    endtask

    task automatic load(input int k, input logic [BW-1:0] v, input int cnt);
        for (int i = 0; i < cnt; i++) fq[k].push_back(v);
    endtask

    task automatic run(input string tag);
        logic [FN-1:0] ep;
        logic          ok;
        sbe_t          s;
        foreach (vecs[i]) begin
            ready = vecs[i].ready;
            mode  = vecs[i].mode;
            if (vecs[i].ready && vecs[i].exp >= 0) begin
                s.idx = vecs[i].exp;
                s.bst = vecs[i].bst;
                sb.push_back(s);
            end
            @(negedge clk);
            nvec++;
            if (vecs[i].exp < 0) begin
                ok = !valid_o && pop == '0;
            end else begin
                ep = vecs[i].ready ? (FN'(1) << vecs[i].exp) : '0;
                ok = valid_o && int'(sel_o) == vecs[i].exp && pop == ep
                     && burst_o == vecs[i].bst;
            end
            if (!ok) begin
                nerr++;
                $display("FAIL %s[%0d]: valid=%b sel=%0d pop=%b burst=%h, want sel=%0d (-1 idle) ready=%b burst=%h",
                         tag, i, valid_o, sel_o, pop, burst_o, vecs[i].exp,
                         vecs[i].ready, vecs[i].bst);
            end
            @(posedge clk);
            #1;
        end
        vecs.delete();
    endtask

    task automatic sb_drain(input string tag);
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL %s_sb_left: %0d pops outstanding, want 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        ready = 1'b0;
        mode  = R;
        for (int k = 0; k < FN; k++) fq[k].delete();
        sb.delete();
        @(negedge clk);
        nvec++;
        if (valid_o || pop != '0 || sel_o != '0 || burst_o != 16'hE000) begin
            nerr++;
            $display("FAIL reset_out: valid=%b pop=%b sel=%0d burst=%h, want 0 0 0 e000",
                     valid_o, pop, sel_o, burst_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clk  = 1'b0;
        nvec = 0;
        nerr = 0;
        pend = '0;
        rst  = 1'b1;
        refresh();

        // Basic: two read FIFOs with different bursts, one bubble each.
        do_reset();
        load(0, 16'h10, 1);
        load(2, 16'h20, 1);
        release_rst();
        add(1, R, -1, 0); add(1, R, 0, 16'h10); add(1, R, -1, 0);
        add(1, R, 2, 16'h20); add(1, R, -1, 0); add(1, R, -1, 0);
        add(1, R, -1, 0);
        run("basic");
        sb_drain("basic");

        // Streak cap of 8 then wrap back to fifo1.
        do_reset();
        load(1, 16'h5, 5);
        load(1, 16'h6, 1);
        load(3, 16'h5, 5);
        release_rst();
        add(1, R, -1, 0);
        for (int i = 0; i < 5; i++) add(1, R, 1, 16'h5);
        for (int i = 0; i < 3; i++) add(1, R, 3, 16'h5);
        add(1, R, -1, 0); add(1, R, 1, 16'h6); add(1, R, -1, 0);
        add(0, R, 3, 16'h5);
        run("cap");
        sb_drain("cap");

        // Stall in ARB holds sel/burst, then a single pop.
        do_reset();
        load(0, 16'h10, 1);
        load(2, 16'h20, 1);
        release_rst();
        add(0, R, -1, 0);
        for (int i = 0; i < 4; i++) add(0, R, 0, 16'h10);
        add(1, R, 0, 16'h10); add(0, R, -1, 0); add(0, R, 2, 16'h20);
        run("stall");
        sb_drain("stall");

        // Mode flip mid-streak; rd_ptr preserved across the write detour.
        do_reset();
        load(0, 16'hA, 1);
        load(1, 16'h7, 3);
        load(3, 16'hB, 1);
        load(5, 16'h9, 1);
        release_rst();
        add(1, R, -1, 0); add(1, R, 0, 16'hA); add(1, R, -1, 0);
        add(1, R, 1, 16'h7); add(1, R, 1, 16'h7); add(1, W, -1, 0);
        add(1, W, 5, 16'h9); add(1, W, -1, 0); add(1, W, -1, 0);
        add(1, R, -1, 0); add(1, R, 3, 16'hB); add(1, R, -1, 0);
        add(1, R, 1, 16'h7); add(1, R, -1, 0); add(1, R, -1, 0);
        run("mode");
        sb_drain("mode");

        // Write class wrap: wr_ptr=2 (global 6) wraps to global 4.
        do_reset();
        mode = W;
        load(6, 16'h1, 1);
        release_rst();
        add(1, W, -1, 0); add(1, W, 6, 16'h1); add(1, W, -1, 0);
        add(1, W, -1, 0);
        run("wrap_a");
        load(4, 16'h2, 1);
        load(6, 16'h3, 1);
        add(1, W, -1, 0); add(1, W, 4, 16'h2); add(1, W, -1, 0);
        add(1, W, 6, 16'h3); add(1, W, -1, 0); add(1, W, -1, 0);
        run("wrap_b");
        sb_drain("wrap");

        // Reset during a streak: no pop, pointers back to reset values.
        do_reset();
        load(0, 16'h4, 4);
        load(1, 16'h9, 1);
        release_rst();
        add(1, R, -1, 0); add(1, R, 0, 16'h4); add(1, R, 0, 16'h4);
        run("rst_a");
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (pop != '0 || valid_o || burst_o != 16'h4) begin
            nerr++;
            $display("FAIL rst_mid: pop=%b valid=%b burst=%h, want 0 0 0004",
                     pop, valid_o, burst_o);
        end
        release_rst();
        add(1, R, -1, 0); add(1, R, 0, 16'h4); add(1, R, 0, 16'h4);
        add(1, R, -1, 0); add(1, R, 1, 16'h9); add(1, R, -1, 0);
        add(1, R, -1, 0);
        run("rst_b");
        sb_drain("rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/cntr_bs_sch_rr.md
Name: cntr_bs_sch_rr

Overview:
- Parametrised bank-scheduler core for the controller front end. Serves one bank's read and write request FIFOs.
- Selects the next FIFO in true round-robin order within the active mode class (read or write).
- Streams burst-address hits from the selected burst, with a configurable cap on streak length so one burst cannot starve the other FIFOs.
- Drives pop to the FIFOs and valid, index and burst address to the arbiter.

Parameters:
- READ, 1'b1, encoding of read mode on `mode`.
- WRITE, 1'b0, encoding of write mode on `mode`.
- RD_FIFO_NUM, 4, read FIFO count (>=1). Occupies indices 0..RD_FIFO_NUM-1.
- WR_FIFO_NUM, 3, write FIFO count (>=1). Occupies indices RD_FIFO_NUM..FIFO_NUM-1.
- BURST, 16, burst-address width.
- MAX_HITS, 8, maximum pops per streak (>=1), including the opening pop.
- Derived: FIFO_NUM = RD_FIFO_NUM+WR_FIFO_NUM; SEL_W = max(1, $clog2(FIFO_NUM)); CNT_W = $clog2(MAX_HITS+1).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, asynchronous and active-high.
- ready, input, 1, arbiter accepts the current request this cycle.
- mode, input, 1, active class: READ or WRITE.
- burst_i, input, [FIFO_NUM-1:0][BURST-1:0], head burst address of each FIFO.
- empty, input, [FIFO_NUM-1:0], FIFO empty flags.
- pop, output, [FIFO_NUM-1:0], one-hot pop to FIFOs. Combinational.
- valid_o, output, 1, request valid to arbiter. Combinational.
- sel_o, output, SEL_W, global index of the FIFO being offered.
- burst_o, output, BURST, equal to burst_i[sel_o].

Behaviour:
- Class mask: when mode==READ, indices 0..RD_FIFO_NUM-1; when mode==WRITE, the write indices. avail = ~empty & class mask.
- State registers: CS in {IDLE, ARB, STREAM}; CB (current burst); rd_ptr, wr_ptr (last-served local index per class); hit_cnt (CNT_W bits).
- On rst: CS=IDLE, CB=0, rd_ptr=RD_FIFO_NUM-1, wr_ptr=WR_FIFO_NUM-1, hit_cnt=0. The outputs are combinational, so they read pop=0, valid_o=0, sel_o=0, burst_o=burst_i[0] while in reset.
- Reset mid-streak: the streak is abandoned immediately and no pop is issued.
- Handshake:
  - pop[sel_o] = valid_o & ready. A pop occurs only on that cycle.
  - When valid_o=1 and ready=0, sel_o and burst_o hold stable unless mode or empty changes.
- IDLE:
  - valid_o=0.
  - If avail!=0, go to ARB next cycle; otherwise stay.
- ARB:
  - If avail==0: valid_o=0, go to IDLE.
  - Otherwise valid_o=1. sel_o is the first set avail bit scanning upward from (class ptr+1), wrapping modulo the class size.
  - If ready: pop, CB<=burst_i[sel_o], class ptr<=local index of sel_o, hit_cnt<=1, go to STREAM.
- STREAM:
  - hits = avail & (burst_i[k]==CB).
  - Continue when hits!=0 and hit_cnt<MAX_HITS. Then valid_o=1, and sel_o is the first hit scanning upward from the class ptr (inclusive), wrapping.
  - On ready: pop, hit_cnt<=hit_cnt+1, class ptr<=local index of sel_o.
  - Otherwise: valid_o=0 and go to ARB. This is exactly one bubble cycle per streak end.
  - When MAX_HITS==1, every streak ends after its opening pop.
- Mode change:
  - The class mask is recomputed combinationally in the same cycle.
  - A streak whose class no longer matches ends, because hits are masked by class; go to ARB.
  - The other class's ptr is untouched.
- Pointer arithmetic: local indices wrap modulo the class size, not modulo a power of two.
- A FIFO going empty while offered with ready=0: valid_o or sel_o re-evaluates in the same cycle. No pop is issued to an empty FIFO.
- hit_cnt saturates at MAX_HITS and never wraps.

Test Plan:
- Reset, mode=READ, FIFOs 0 and 2 non-empty, bursts 0x10 and 0x20, ready=1 → IDLE; ARB pops fifo0 (CB=0x10); STREAM finds no hit, 1 bubble; ARB pops fifo2.
- Read FIFOs 1 and 3 each hold 5 entries of burst 0x5, MAX_HITS=8, ready=1 → pops fifo1 then hits 1,1,1,1,3,3,3 (8 pops); bubble; ARB resumes after ptr=3 at fifo1 (wrap).
- Hold ready=0 for 4 cycles in ARB → valid_o=1, sel_o and burst_o stable, pop=0. Raise ready → exactly one pop.
- mode flips READ→WRITE mid-streak while write FIFO 5 is non-empty → streak ends, bubble cycle, next pop is pop[5]. rd_ptr is unchanged when mode returns.
- WR_FIFO_NUM=3, wr_ptr=2 (global 6), write FIFOs 4 and 6 non-empty → next pick is global 4 (wrap 2→0), not 7.
- Assert rst during STREAM with ready=1 → pop=0 in that cycle; state IDLE, pointers at reset values on release.
